// File: rtl/banked_mem_arbiter.sv
// Multi-requester to multi-bank memory arbiter: one IDLE/ISSUE/WAIT controller per bank,
// round-robin grant among idle requesters, timeout error response if a bank never completes.
module banked_mem_arbiter #(
  parameter int N_REQ   = 3,
  parameter int N_BANK  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0]               req_we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]               req_ready,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [N_REQ-1:0]               rsp_err,
  output logic [N_REQ-1:0][DATA_W-1:0]   rsp_rdata,
  output logic [N_BANK-1:0]              bank_valid,
  output logic [N_BANK-1:0]              bank_we,
  output logic [N_BANK-1:0][ADDR_W-1:0]  bank_addr,
  output logic [N_BANK-1:0][DATA_W-1:0]  bank_wdata,
  input  logic [N_BANK-1:0]              bank_ready,
  input  logic [N_BANK-1:0]              bank_rsp_valid,
  input  logic [N_BANK-1:0][DATA_W-1:0]  bank_rdata
);

  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state  [N_BANK];
  logic [RW-1:0]     rr_ptr [N_BANK];
  logic [RW-1:0]     owner  [N_BANK];
  logic [CW-1:0]     cnt    [N_BANK];
  logic [RW-1:0]     gnt_idx[N_BANK];
  logic [N_BANK-1:0] gnt_vld;
  logic [N_REQ-1:0]  busy;
  logic [N_REQ-1:0]  eligible;

  function automatic int bank_of(input logic [BW-1:0] a);
    return int'(a) & (N_BANK - 1);
  endfunction

  // A requester whose response is on the bus this cycle may already be granted again.
  assign eligible = req_valid & (~busy | rsp_valid);

  always_comb begin
    int r;
    r         = 0;
    gnt_vld   = '0;
    req_ready = '0;
    for (int b = 0; b < N_BANK; b++) begin
      gnt_idx[b] = '0;
      if (state[b] == IDLE) begin
        for (int k = 0; k < N_REQ; k++) begin
          r = (int'(rr_ptr[b]) + k) % N_REQ;
          if (!gnt_vld[b] && eligible[r] && bank_of(req_addr[r][BW-1:0]) == b) begin
            gnt_vld[b] = 1'b1;
            gnt_idx[b] = RW'(r);
          end
        end
      end
      if (gnt_vld[b]) req_ready[gnt_idx[b]] = resetN;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int b = 0; b < N_BANK; b++) begin
        state[b]  <= IDLE;
        rr_ptr[b] <= '0;
        owner[b]  <= '0;
        cnt[b]    <= '0;
      end
      busy       <= '0;
      bank_valid <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      rsp_valid  <= '0;
      rsp_err    <= '0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
      busy      <= (busy & ~rsp_valid) | req_ready;
      for (int b = 0; b < N_BANK; b++) begin
        unique case (state[b])
          IDLE: begin
            if (gnt_vld[b]) begin
              owner[b]      <= gnt_idx[b];
              bank_we[b]    <= req_we[gnt_idx[b]];
              bank_addr[b]  <= req_addr[gnt_idx[b]];
              bank_wdata[b] <= req_wdata[gnt_idx[b]];
              bank_valid[b] <= 1'b1;
              rr_ptr[b]     <= (int'(gnt_idx[b]) == N_REQ - 1) ? '0 : gnt_idx[b] + 1'b1;
              state[b]      <= ISSUE;
            end
          end
          ISSUE: begin
            if (bank_ready[b]) begin
              bank_valid[b] <= 1'b0;
              cnt[b]        <= '0;
              state[b]      <= WAIT;
            end
          end
          WAIT: begin
            // A completion arriving on the last allowed cycle still beats the timeout.
            if (bank_rsp_valid[b]) begin
              rsp_valid[owner[b]] <= 1'b1;
              rsp_rdata[owner[b]] <= bank_we[b] ? '0 : bank_rdata[b];
              state[b]            <= IDLE;
            end else if (cnt[b] == CW'(TIMEOUT - 1)) begin
              rsp_valid[owner[b]] <= 1'b1;
              rsp_err[owner[b]]   <= 1'b1;
              state[b]            <= IDLE;
            end else begin
              cnt[b] <= cnt[b] + 1'b1;
            end
          end
          default: state[b] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/banked_mem_arbiter.md
BANKED_MEM_ARBITER -- requirements
Module: banked_mem_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requester ports (1..8).
REQ-002 SHALL have parameter N_BANK, default 2, number of memory banks (power of 2, 1..8).
REQ-003 SHALL have parameter ADDR_W, default 16, address width.
REQ-004 SHALL have parameter DATA_W, default 16, data width.
REQ-005 SHALL have parameter TIMEOUT, default 64, max WAIT cycles before error response (>=2).
REQ-006 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-007 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports req_valid/req_we, input, [N_REQ], request valid / write enable.
REQ-009 SHALL have ports req_addr/req_wdata, input, [N_REQ][ADDR_W]/[N_REQ][DATA_W], request address / write data.
REQ-010 SHALL have port req_ready, output, [N_REQ], request accepted this cycle.
REQ-011 SHALL have ports rsp_valid/rsp_err, output, [N_REQ], one-cycle response pulse / timeout flag.
REQ-012 SHALL have port rsp_rdata, output, [N_REQ][DATA_W], read data.
REQ-013 SHALL have ports bank_valid/bank_we, output, [N_BANK], bank command valid / write.
REQ-014 SHALL have ports bank_addr/bank_wdata, output, [N_BANK][ADDR_W]/[N_BANK][DATA_W], bank command address / data.
REQ-015 SHALL have port bank_ready, input, [N_BANK], bank accepts command.
REQ-016 SHALL have ports bank_rsp_valid/bank_rdata, input, [N_BANK]/[N_BANK][DATA_W], bank completion / read data.

Function
REQ-017 SHALL select target bank as req_addr[log2(N_BANK)-1:0]; full req_addr is forwarded unchanged to the bank.
REQ-018 SHALL run per bank an FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-019 IDLE: among requesters with req_valid, target == this bank and not busy, SHALL grant one by round-robin starting at rr_ptr, assert req_ready[grant] combinationally, latch we/addr/wdata and grant index, go to ISSUE.
REQ-020 SHALL update rr_ptr to (grant+1) mod N_REQ on each grant; rr_ptr unchanged when no grant.
REQ-021 ISSUE: bank_valid SHALL be 1 with stable command fields until bank_ready=1, then go to WAIT with timeout counter cleared.
REQ-022 WAIT: on bank_rsp_valid, SHALL register rsp_valid=1, rsp_err=0 to the owner, rsp_rdata=bank_rdata for reads and 0 for writes, in the following cycle, and return to IDLE.
REQ-023 WAIT: if counter reaches TIMEOUT-1 without bank_rsp_valid, SHALL next cycle pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 to the owner and return to IDLE.
REQ-024 If bank_rsp_valid coincides with the timeout cycle, response SHALL win (rsp_err=0).
REQ-025 bank_rsp_valid outside WAIT SHALL be ignored (late responses after timeout dropped).
REQ-026 A requester SHALL be marked busy on grant and cleared in the cycle its rsp_valid is high; it is eligible for a new grant in that same cycle.
REQ-027 A bank SHALL be IDLE (able to grant) in the cycle its rsp_valid is driven; minimum accept-to-accept interval is 3 cycles with zero-latency bank.
REQ-028 Banks SHALL operate independently; requesters targeting different banks may be granted in the same cycle.
REQ-029 rsp_valid SHALL be exactly one cycle per accepted request; req_ready is 0 whenever not granted.

Reset
REQ-030 On resetN=0, SHALL asynchronously force all FSMs to IDLE, rr_ptr=0, busy=0, counters=0, bank_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, bank command fields=0.
REQ-031 Reset mid-transaction SHALL discard the transaction with no rsp_valid emitted; after release, first grant occurs no earlier than the first rising edge with resetN=1.

Verification
REQ-032 Single read: req 0 reads addr 0x0010 (bank 0), bank_ready=1, bank_rsp_valid next cycle with 0xBEEF -> req_ready[0] at t, bank_valid at t+1, rsp_valid[0]=1 rsp_rdata=0xBEEF at t+3.
REQ-033 Contention: reqs 0,1,2 all hold valid to bank 1 continuously -> grants in order 0,1,2,0, each rsp_err=0.
REQ-034 Parallel banks: req 0 to addr 0x0002 (bank 0), req 1 to 0x0003 (bank 1) same cycle -> both req_ready in same cycle, both rsp_valid in same cycle.
REQ-035 Timeout: TIMEOUT=4, bank never responds -> rsp_valid=1 rsp_err=1 rsp_rdata=0 five cycles after bank_ready; later bank_rsp_valid ignored.
REQ-036 Backpressure: bank_ready=0 for 5 cycles -> bank_valid and command stable for 6 cycles, no timeout counting.
REQ-037 Reset in WAIT: resetN pulsed low -> all outputs 0 immediately, no rsp_valid after release.
